mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Registers the execute-stage result and control word, and performs the data-memory access for loads and stores.
- Aligns load data and store data, and fills the memory fields of the RVFI control word.
- Presents forwarding data and a valid/ready handshake to writeback.

Parameters:
XLEN, 32, datapath width; only 32 supported.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; asynchronous, active-low.
ctrl_w  in  control_word  control word from execute (exe/mem/wb/rvfi groups).
alu_in  in  32  execute ALU result; effective address for loads and stores.
rs2_in  in  32  forwarded rs2 value; store data source.
br_en_in  in  1  execute compare result.
exe_mem_valid  in  1  execute presents a valid instruction.
mem_rdy  out  1  MEM can accept this cycle.
dmem_address  out  32  word-aligned data address.
dmem_read  out  1  read request.
dmem_write  out  1  write request.
dmem_wmask  out  4  byte write enables.
dmem_wdata  out  32  lane-aligned store data.
dmem_rdata  in  32  read data.
dmem_resp  in  1  one-cycle access completion.
mem_fwd_data  out  32  forwarding value: load result for loads, registered ALU result otherwise.
mem_wb_valid  out  1  result valid to writeback.
wb_rdy  in  1  writeback accepts.
misalign  out  1  held with a misaligned load/store result.
rvfi_mem  out  control_word  registered control word with memory RVFI fields filled.

Behaviour:
- Reset state: rst low sets state IDLE and clears all outputs and registers to 0. Exceptions: rvfi_mem.rvfi.pc_rdata=32'h40000000; mem_rdy=1.
- Reset is asynchronous. Asserting it mid-access drops dmem_read/dmem_write in the same cycle. A later dmem_resp is ignored.
- Accept: a transfer occurs on a rising edge where exe_mem_valid && mem_rdy.
  - Registers ctrl_w, alu_in, rs2_in and br_en_in.
  - Computes offset = alu_in[1:0].
- mem_rdy = (state==IDLE) || (state==DONE && wb_rdy).
- FSM:
  - IDLE: on accept, go to ACCESS if mem_read_d or mem_write_d; otherwise go to DONE.
  - ACCESS: hold dmem_read (load) or dmem_write (store) high every cycle, with address/mask/data held stable, until dmem_resp. On dmem_resp, capture dmem_rdata and go to DONE. Requests deassert in the cycle after resp.
  - DONE: mem_wb_valid=1. If wb_rdy: accept a new instruction in the same cycle (go to ACCESS, DONE or IDLE as above), or go to IDLE if there is none. If !wb_rdy: hold all outputs stable.
- Latency:
  - Non-memory instruction: valid one cycle after accept.
  - Memory instruction: valid one cycle after dmem_resp.
  - Zero-wait memory: access completes in the first ACCESS cycle.
- Address: dmem_address = {addr[31:2],2'b00}.
- Stores:
  - sb: wmask = 4'b0001<<offset; wdata = rs2[7:0] replicated ×4.
  - sh: wmask = 4'b0011<<offset; wdata = rs2[15:0] replicated ×2.
  - sw: wmask = 4'b1111; wdata = rs2.
- Loads:
  - rmask uses the same shapes as the store masks.
  - Data = selected byte/halfword of rdata, shifted by 8×offset.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw takes rdata whole.
- Misaligned (sh/lh/lhu with offset 3, or offset[0]=1; sw/lw with offset≠0):
  - No bus request is issued; go directly to DONE.
  - misalign=1; rvfi_mem.rvfi.valid_commit forced to 0; mem_fwd_data = 0 for loads.
- RVFI fields:
  - mem_addr = dmem_address.
  - rmask / wmask as computed.
  - mem_rdata = captured raw rdata.
  - mem_wdata = aligned wdata.
  - rd_wdata = mem_fwd_data when wb.ld_reg and rd_sel≠0, else 0.
  - All other fields pass through unchanged.
- br_en_in is registered and passed through.
- When not in DONE, mem_wb_valid=0. rvfi_mem is then a bubble: zero controls, valid_commit=0.

Test Plan:
- ALU op (alu_in=32'h1234, no mem) accepted at t → at t+1 mem_wb_valid=1, mem_fwd_data=32'h1234, no dmem request.
- lb at alu_in=32'h1003; memory returns rdata=32'h80FF_FF01 after 3 wait cycles → dmem_read held 4 cycles at 32'h1000; rmask=4'b1000; result=32'hFFFF_FF80.
- sh at 32'h2002 with rs2=32'hABCD_1234, zero-wait → dmem_write for one cycle; wmask=4'b1100; wdata=32'h1234_1234.
- lw at 32'h3001 → no bus request; misalign=1; valid_commit=0.
- DONE with wb_rdy=0 for 5 cycles → outputs stable, mem_rdy=0. wb_rdy=1 with exe_mem_valid=1 → back-to-back accept.
- rst pulled low during ACCESS → dmem_read=0 immediately; state IDLE; a late dmem_resp produces no mem_wb_valid.

Source files
------------

// File: rtl/mem_stage_if.sv
// Control-word types shared along the pipeline, and the data-memory bus driven by the MEM stage.
package mem_stage_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
  } exe_ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic       ld_reg;
    logic [4:0] rd_sel;
    logic [1:0] wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid_commit;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    exe_ctrl_t exe;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    rvfi_t     rvfi;
  } control_word;

endpackage

interface mem_stage_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: registers the execute result, runs the data-memory access with
// byte-lane alignment, and hands a valid/ready result plus RVFI memory fields to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  control_word      ctrl_w,
  input  logic [XLEN-1:0]  alu_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic             br_en_in,
  input  logic             exe_mem_valid,
  output logic             mem_rdy,
  mem_stage_if.master      dmem,
  output logic [XLEN-1:0]  mem_fwd_data,
  output logic             mem_wb_valid,
  input  logic             wb_rdy,
  output logic             misalign,
  output logic             br_en,
  output control_word      rvfi_mem
);

  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  control_word     cw_reg;
  logic [XLEN-1:0] alu_reg;
  logic [XLEN-1:0] rs2_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            br_en_reg;
  logic            misalign_reg;

  logic            accept;
  logic            acc_is_mem;
  logic            acc_misalign;
  logic            is_load;
  logic            is_store;
  logic [1:0]      offset;
  logic [3:0]      size_mask;
  logic [3:0]      lane_mask;
  logic [3:0]      rmask_val;
  logic [3:0]      wmask_val;
  logic [31:0]     store_data;
  logic [31:0]     wdata_val;
  logic [31:0]     shifted;
  logic [31:0]     load_data;

  // Alignment of the incoming access is judged before registering so a misaligned
  // instruction can skip the bus entirely.
  assign acc_is_mem = ctrl_w.mem.mem_read | ctrl_w.mem.mem_write;

  always_comb begin
    case (ctrl_w.mem.funct3[1:0])
      2'b00:   acc_misalign = 1'b0;
      2'b01:   acc_misalign = alu_in[0];
      default: acc_misalign = |alu_in[1:0];
    endcase
    acc_misalign = acc_misalign & acc_is_mem;
  end

  assign accept = exe_mem_valid && mem_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mem_rdy      = 1'b0;
    mem_wb_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        mem_rdy = 1'b1;
        if (exe_mem_valid) begin
          state_next = (acc_is_mem && !acc_misalign) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (dmem.dmem_resp) begin
          state_next = DONE;
        end
      end
      DONE: begin
        mem_wb_valid = 1'b1;
        if (wb_rdy) begin
          mem_rdy = 1'b1;
          if (exe_mem_valid) begin
            state_next = (acc_is_mem && !acc_misalign) ? ACCESS : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_reg               <= '0;
      cw_reg.rvfi.pc_rdata <= RESET_PC;
      alu_reg              <= '0;
      rs2_reg              <= '0;
      rdata_reg            <= '0;
      br_en_reg            <= 1'b0;
      misalign_reg         <= 1'b0;
    end else if (accept) begin
      cw_reg       <= ctrl_w;
      alu_reg      <= alu_in;
      rs2_reg      <= rs2_in;
      br_en_reg    <= br_en_in;
      misalign_reg <= acc_misalign;
      rdata_reg    <= '0;
    end else if (state_reg == ACCESS && dmem.dmem_resp) begin
      rdata_reg <= dmem.dmem_rdata;
    end
  end

  assign is_load  = cw_reg.mem.mem_read;
  assign is_store = cw_reg.mem.mem_write;
  assign offset   = alu_reg[1:0];

  always_comb begin
    case (cw_reg.mem.funct3[1:0])
      2'b00: begin
        size_mask  = 4'b0001;
        store_data = {4{rs2_reg[7:0]}};
      end
      2'b01: begin
        size_mask  = 4'b0011;
        store_data = {2{rs2_reg[15:0]}};
      end
      default: begin
        size_mask  = 4'b1111;
        store_data = rs2_reg;
      end
    endcase
  end

  assign lane_mask = size_mask << offset;
  assign rmask_val = (is_load && !misalign_reg) ? lane_mask : 4'b0000;
  assign wmask_val = (is_store && !misalign_reg) ? lane_mask : 4'b0000;
  assign wdata_val = is_store ? store_data : 32'd0;

  // The addressed lane is brought down to bit 0 before extension.
  assign shifted = rdata_reg >> {offset, 3'b000};

  always_comb begin
    case (cw_reg.mem.funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign dmem.dmem_address = {alu_reg[31:2], 2'b00};
  assign dmem.dmem_read    = (state_reg == ACCESS) && is_load;
  assign dmem.dmem_write   = (state_reg == ACCESS) && is_store;
  assign dmem.dmem_wmask   = wmask_val;
  assign dmem.dmem_wdata   = wdata_val;

  assign mem_fwd_data = is_load ? (misalign_reg ? 32'd0 : load_data) : alu_reg;
  assign misalign     = misalign_reg && (state_reg == DONE);
  assign br_en        = br_en_reg;

  // Outside DONE the word is a bubble so downstream never commits a stale instruction.
  always_comb begin
    rvfi_mem = cw_reg;
    if (state_reg == DONE) begin
      rvfi_mem.rvfi.mem_addr     = dmem.dmem_address;
      rvfi_mem.rvfi.mem_rmask    = rmask_val;
      rvfi_mem.rvfi.mem_wmask    = wmask_val;
      rvfi_mem.rvfi.mem_rdata    = rdata_reg;
      rvfi_mem.rvfi.mem_wdata    = wdata_val;
      rvfi_mem.rvfi.rd_wdata     = (cw_reg.wb.ld_reg && (cw_reg.wb.rd_sel != 5'd0)) ?
                                   mem_fwd_data : 32'd0;
      rvfi_mem.rvfi.valid_commit = cw_reg.rvfi.valid_commit & ~misalign_reg;
    end else begin
      rvfi_mem.exe               = '0;
      rvfi_mem.mem               = '0;
      rvfi_mem.wb                = '0;
      rvfi_mem.rvfi.valid_commit = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each instruction's expected result is computed from the
// load/store rules with plain arithmetic and compared at every cycle of its lifetime.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  control_word ctrl_w;
  logic [31:0] alu_in;
  logic [31:0] rs2_in;
  logic        br_en_in;
  logic        exe_mem_valid;
  logic        mem_rdy;
  logic [31:0] mem_fwd_data;
  logic        mem_wb_valid;
  logic        wb_rdy;
  logic        misalign;
  logic        br_en;
  control_word rvfi_mem;

  mem_stage_if dmem_bus ();

  mem_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_w       (ctrl_w),
    .alu_in       (alu_in),
    .rs2_in       (rs2_in),
    .br_en_in     (br_en_in),
    .exe_mem_valid(exe_mem_valid),
    .mem_rdy      (mem_rdy),
    .dmem         (dmem_bus),
    .mem_fwd_data (mem_fwd_data),
    .mem_wb_valid (mem_wb_valid),
    .wb_rdy       (wb_rdy),
    .misalign     (misalign),
    .br_en        (br_en),
    .rvfi_mem     (rvfi_mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        access;
    logic        mis;
    logic [31:0] fwd;
    control_word rv;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected behaviour from the access size and byte offset, independent of lane muxing.
  function automatic exp_t model(control_word cw, logic [31:0] alu, logic [31:0] rs2,
                                 logic [31:0] rdata);
    exp_t        e;
    int          size;
    int          off;
    bit          ld;
    bit          st;
    logic [63:0] low;
    logic [63:0] v;
    logic [31:0] rep;
    logic [31:0] wd;
    logic [3:0]  mask;
    size = 1 << cw.mem.funct3[1:0];
    off  = int'(alu % 32'd4);
    ld   = cw.mem.mem_read;
    st   = cw.mem.mem_write;
    e.mis    = (ld || st) && ((alu % size) != 0);
    e.access = (ld || st) && !e.mis;
    low  = (64'd1 << (8 * size)) - 64'd1;
    mask = 4'(((1 << size) - 1) << off);
    rep  = (size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h1;
    wd   = 32'((64'(rs2) & low) * 64'(rep));
    v    = (64'(e.access ? rdata : 32'd0) >> (8 * off)) & low;
    if (!cw.mem.funct3[2] && v[8 * size - 1]) v = v | ~low;
    e.fwd = ld ? (e.mis ? 32'd0 : v[31:0]) : alu;
    e.rv = cw;
    e.rv.rvfi.mem_addr     = alu & ~32'd3;
    e.rv.rvfi.mem_rmask    = (ld && !e.mis) ? mask : 4'd0;
    e.rv.rvfi.mem_wmask    = (st && !e.mis) ? mask : 4'd0;
    e.rv.rvfi.mem_rdata    = e.access ? rdata : 32'd0;
    e.rv.rvfi.mem_wdata    = st ? wd : 32'd0;
    e.rv.rvfi.rd_wdata     = (cw.wb.ld_reg && cw.wb.rd_sel != 5'd0) ? e.fwd : 32'd0;
    e.rv.rvfi.valid_commit = cw.rvfi.valid_commit && !e.mis;
    return e;
  endfunction

  // kind: 0 = non-memory, 1 = load, 2 = store
  function automatic control_word rand_cw(int kind);
    logic [415:0] raw;
    control_word  cw;
    int           lf[5] = '{0, 1, 2, 4, 5};
    for (int i = 0; i < 13; i++) raw[i*32 +: 32] = $urandom;
    cw = raw[$bits(control_word)-1:0];
    cw.mem.mem_read  = (kind == 1);
    cw.mem.mem_write = (kind == 2);
    if (kind == 1) cw.mem.funct3 = 3'(lf[$urandom_range(0, 4)]);
    if (kind == 2) cw.mem.funct3 = 3'($urandom_range(0, 2));
    return cw;
  endfunction

  task automatic scramble_inputs();
    ctrl_w        = rand_cw($urandom_range(0, 2));
    alu_in        = $urandom;
    rs2_in        = $urandom;
    br_en_in      = 1'($urandom);
    exe_mem_valid = 1'($urandom);
  endtask

  task automatic check_done(input exp_t e, input logic br);
    check_eq("wb_valid", 512'(mem_wb_valid), 512'(1'b1));
    check_eq("rdy_stall", 512'(mem_rdy), 512'(1'b0));
    check_eq("done_rd", 512'(dmem_bus.dmem_read), 512'(1'b0));
    check_eq("done_wr", 512'(dmem_bus.dmem_write), 512'(1'b0));
    check_eq("fwd", 512'(mem_fwd_data), 512'(e.fwd));
    check_eq("misalign", 512'(misalign), 512'(e.mis));
    check_eq("br_en", 512'(br_en), 512'(br));
    check_eq("rvfi", 512'(rvfi_mem), 512'(e.rv));
  endtask

  // Entered at a negedge with the DUT in IDLE or DONE; leaves at a negedge in DONE, wb_rdy=0.
  task automatic do_instr(input control_word cw, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic br, input logic [31:0] rdata, input int waits,
                          input int stall);
    exp_t e;
    e = model(cw, alu, rs2, rdata);
    ctrl_w        = cw;
    alu_in        = alu;
    rs2_in        = rs2;
    br_en_in      = br;
    exe_mem_valid = 1'b1;
    wb_rdy        = 1'b1;
    #1;
    check_eq("rdy_accept", 512'(mem_rdy), 512'(1'b1));
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    wb_rdy = 1'b0;
    #1;
    if (e.access) begin
      for (int k = 0; k <= waits; k++) begin
        check_eq("req_rd", 512'(dmem_bus.dmem_read), 512'(cw.mem.mem_read));
        check_eq("req_wr", 512'(dmem_bus.dmem_write), 512'(cw.mem.mem_write));
        check_eq("req_addr", 512'(dmem_bus.dmem_address), 512'(e.rv.rvfi.mem_addr));
        check_eq("req_wmask", 512'(dmem_bus.dmem_wmask), 512'(e.rv.rvfi.mem_wmask));
        check_eq("req_wdata", 512'(dmem_bus.dmem_wdata), 512'(e.rv.rvfi.mem_wdata));
        check_eq("req_novalid", 512'(mem_wb_valid), 512'(1'b0));
        if (k == waits) begin
          dmem_bus.dmem_resp  = 1'b1;
          dmem_bus.dmem_rdata = rdata;
        end
        @(posedge clk);
        @(negedge clk);
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = $urandom;
        #1;
      end
    end
    for (int s = 0; s <= stall; s++) begin
      check_done(e, br);
      if (s < stall) begin
        scramble_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_gap();
    wb_rdy        = 1'b1;
    exe_mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("idle_valid", 512'(mem_wb_valid), 512'(1'b0));
    check_eq("idle_rdy", 512'(mem_rdy), 512'(1'b1));
    check_eq("idle_commit", 512'(rvfi_mem.rvfi.valid_commit), 512'(1'b0));
    check_eq("idle_rd", 512'(dmem_bus.dmem_read), 512'(1'b0));
  endtask

  initial begin
    control_word cw;
    int          kind;
    ctrl_w              = '0;
    alu_in              = '0;
    rs2_in              = '0;
    br_en_in            = 1'b0;
    exe_mem_valid       = 1'b0;
    wb_rdy              = 1'b0;
    dmem_bus.dmem_resp  = 1'b0;
    dmem_bus.dmem_rdata = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_rdy", 512'(mem_rdy), 512'(1'b1));
    check_eq("rst_valid", 512'(mem_wb_valid), 512'(1'b0));
    check_eq("rst_rd", 512'(dmem_bus.dmem_read), 512'(1'b0));
    check_eq("rst_wr", 512'(dmem_bus.dmem_write), 512'(1'b0));
    check_eq("rst_wmask", 512'(dmem_bus.dmem_wmask), 512'(4'b0));
    check_eq("rst_addr", 512'(dmem_bus.dmem_address), 512'(32'd0));
    check_eq("rst_fwd", 512'(mem_fwd_data), 512'(32'd0));
    check_eq("rst_mis", 512'(misalign), 512'(1'b0));
    check_eq("rst_pc", 512'(rvfi_mem.rvfi.pc_rdata), 512'(32'h4000_0000));
    check_eq("rst_commit", 512'(rvfi_mem.rvfi.valid_commit), 512'(1'b0));
    rst = 1'b1;

    // Directed cases from the block's reference scenarios.
    cw = rand_cw(0);
    cw.rvfi.valid_commit = 1'b1;
    cw.wb.ld_reg = 1'b1;
    cw.wb.rd_sel = 5'd5;
    do_instr(cw, 32'h1234, 32'h0, 1'b1, 32'h0, 0, 0);
    cw.mem.mem_read = 1'b1;
    cw.mem.funct3   = 3'b000;
    do_instr(cw, 32'h1003, 32'h0, 1'b0, 32'h80FF_FF01, 3, 0);
    cw.mem.mem_read  = 1'b0;
    cw.mem.mem_write = 1'b1;
    cw.mem.funct3    = 3'b001;
    do_instr(cw, 32'h2002, 32'hABCD_1234, 1'b0, 32'h5555_AAAA, 0, 0);
    cw.mem.mem_write = 1'b0;
    cw.mem.mem_read  = 1'b1;
    cw.mem.funct3    = 3'b010;
    do_instr(cw, 32'h3001, 32'h0, 1'b0, 32'h0, 0, 0);
    cw.mem.mem_read = 1'b0;
    do_instr(cw, 32'hCAFE_0000, 32'h0, 1'b1, 32'h0, 0, 5);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 2);
      do_instr(rand_cw(kind), $urandom, $urandom, 1'($urandom), $urandom,
               $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      if ($urandom_range(0, 4) == 0) idle_gap();
    end

    // Reset in the middle of a long access; the late response must be ignored.
    cw = rand_cw(1);
    cw.mem.funct3 = 3'b010;
    ctrl_w        = cw;
    alu_in        = 32'h100;
    exe_mem_valid = 1'b1;
    wb_rdy        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exe_mem_valid = 1'b0;
    wb_rdy        = 1'b0;
    #1;
    check_eq("rst_pre_req", 512'(dmem_bus.dmem_read), 512'(1'b1));
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_async_rd", 512'(dmem_bus.dmem_read), 512'(1'b0));
    check_eq("rst_async_rdy", 512'(mem_rdy), 512'(1'b1));
    check_eq("rst_async_valid", 512'(mem_wb_valid), 512'(1'b0));
    @(negedge clk);
    rst                = 1'b1;
    dmem_bus.dmem_resp = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_bus.dmem_resp = 1'b0;
    #1;
    check_eq("late_resp_valid", 512'(mem_wb_valid), 512'(1'b0));
    check_eq("late_resp_rd", 512'(dmem_bus.dmem_read), 512'(1'b0));
    check_eq("late_resp_pc", 512'(rvfi_mem.rvfi.pc_rdata), 512'(32'h4000_0000));
    @(posedge clk);
    @(negedge clk);
    check_eq("late_resp_valid2", 512'(mem_wb_valid), 512'(1'b0));
    do_instr(rand_cw(2), 32'h44, $urandom, 1'b1, $urandom, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
